// File: rtl/fifo_refill_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_refill_sched_if
// Brief    : Descriptor, RAM-read and FIFO-write bundle of the refill scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_refill_sched_if #(
  parameter int NCH    = 4,
  parameter int RAM_AW = 8,
  parameter int DW     = 24,
  parameter int FDW    = 4,
  parameter int BLKW   = 4
);
  logic                    enable;
  logic [NCH-1:0]          desc_valid;
  logic [NCH-1:0]          desc_ready;
  logic [NCH*RAM_AW-1:0]   desc_saddr;
  logic [NCH*RAM_AW-1:0]   desc_eaddr;
  logic [NCH-1:0]          desc_last;
  logic [NCH*(FDW+1)-1:0]  fifo_count;
  logic                    ren;
  logic [RAM_AW-1:0]       raddr;
  logic [RAM_AW-1:0]       rlength;
  logic                    dvalid;
  logic                    dlast;
  logic [DW-1:0]           dout;
  logic [NCH-1:0]          fifo_wrreq;
  logic [NCH*DW-1:0]       fifo_data;
  logic                    blk_done;
  logic [BLKW-1:0]         blk_ptr;
  logic                    err;

  modport slave (
    input  enable, desc_valid, desc_saddr, desc_eaddr, desc_last, fifo_count,
    input  dvalid, dlast, dout,
    output desc_ready, ren, raddr, rlength, fifo_wrreq, fifo_data,
    output blk_done, blk_ptr, err
  );

  modport master (
    output enable, desc_valid, desc_saddr, desc_eaddr, desc_last, fifo_count,
    output dvalid, dlast, dout,
    input  desc_ready, ren, raddr, rlength, fifo_wrreq, fifo_data,
    input  blk_done, blk_ptr, err
  );
endinterface
`default_nettype wire

// File: rtl/fifo_refill_sched.sv
`default_nettype none
// ============================================================================
// Module   : fifo_refill_sched
// Brief    : Schedules bounded RAM read bursts into per-channel FIFOs, with
//            round-robin fairness and an output-block barrier across channels.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_refill_sched #(
  parameter int NCH       = 4,
  parameter int RAM_AW    = 8,
  parameter int DW        = 24,
  parameter int FDW       = 4,
  parameter int BURST_MAX = 8,
  parameter int BLKW      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_refill_sched_if.slave io_bus
);
  localparam int                GW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int                CW     = FDW + 1;
  localparam logic [CW-1:0]     c_depth = CW'(2**FDW);
  localparam logic [CW-1:0]     c_half  = CW'(2**(FDW-1));
  localparam logic [RAM_AW-1:0] c_bmax  = RAM_AW'(BURST_MAX);

  typedef enum logic [1:0] {CH_EMPTY, CH_ACTIVE, CH_HOLD} ch_state_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} sched_state_t;

  ch_state_t          r_ch_state [NCH];
  logic [RAM_AW-1:0]  r_cur      [NCH];
  logic [RAM_AW-1:0]  r_end      [NCH];
  logic               r_last     [NCH];

  logic [RAM_AW-1:0]  w_remain   [NCH];
  logic [RAM_AW-1:0]  w_len      [NCH];
  logic [NCH-1:0]     w_cls_a;
  logic [NCH-1:0]     w_cls_b;
  logic [NCH-1:0]     w_cur_inc;
  logic [NCH-1:0]     w_sel;
  logic               w_all_hold;
  logic               w_gnt_vld;
  logic [GW-1:0]      w_gnt;
  logic [GW-1:0]      w_idx;
  logic [RAM_AW-1:0]  w_beat_nxt;
  logic [DW-1:0]      w_dout;

  sched_state_t       r_state;
  logic [GW-1:0]      r_gnt;
  logic [GW-1:0]      r_last_gnt;
  logic               r_ren;
  logic [RAM_AW-1:0]  r_raddr;
  logic [RAM_AW-1:0]  r_rlength;
  logic [RAM_AW-1:0]  r_beat;
  logic               r_err;
  logic               r_blk_done;
  logic [BLKW-1:0]    r_blk_ptr;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_free;
    logic [RAM_AW-1:0] w_rb;
    logic              w_elig;

    assign w_count     = io_bus.fifo_count[i*CW +: CW];
    assign w_free      = c_depth - w_count;
    // Modular difference keeps wrap-around address ranges legal.
    assign w_remain[i] = r_end[i] - r_cur[i];
    assign w_elig      = (r_ch_state[i] == CH_ACTIVE) && (w_remain[i] != '0)
                         && (w_count < c_depth);
    assign w_cls_a[i]  = w_elig && (w_count == '0);
    assign w_cls_b[i]  = w_elig && (w_count < c_half);
    assign w_rb        = (w_remain[i] < c_bmax) ? w_remain[i] : c_bmax;
    assign w_len[i]    = (32'(w_free) < 32'(w_rb)) ? RAM_AW'(w_free) : w_rb;

    assign w_cur_inc[i] = (r_state == S_DATA) && io_bus.dvalid && io_bus.dlast
                          && (r_gnt == GW'(i));

    assign io_bus.desc_ready[i] = (r_ch_state[i] == CH_EMPTY);
    assign io_bus.fifo_wrreq[i] = (r_state == S_DATA) && io_bus.dvalid
                                  && (r_gnt == GW'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ch_state[i] <= CH_EMPTY;
        r_cur[i]      <= '0;
        r_end[i]      <= '0;
        r_last[i]     <= 1'b0;
      end else if (w_all_hold) begin
        r_ch_state[i] <= CH_EMPTY;
      end else begin
        case (r_ch_state[i])
          CH_EMPTY: begin
            if (io_bus.desc_valid[i]) begin
              r_cur[i]      <= io_bus.desc_saddr[i*RAM_AW +: RAM_AW];
              r_end[i]      <= io_bus.desc_eaddr[i*RAM_AW +: RAM_AW];
              r_last[i]     <= io_bus.desc_last[i];
              r_ch_state[i] <= CH_ACTIVE;
            end
          end
          CH_ACTIVE: begin
            if (w_cur_inc[i]) begin
              r_cur[i] <= r_cur[i] + r_rlength;
            end else if (w_remain[i] == '0) begin
              r_ch_state[i] <= r_last[i] ? CH_HOLD : CH_EMPTY;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_all_hold = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (r_ch_state[k] != CH_HOLD) w_all_hold = 1'b0;
    end
  end

  // Starving (empty) FIFOs pre-empt half-full ones; rotation starts after the
  // previous winner, so scanning from the far end leaves the nearest as winner.
  always_comb begin
    w_sel     = (|w_cls_a) ? w_cls_a : w_cls_b;
    w_gnt_vld = 1'b0;
    w_gnt     = r_last_gnt;
    w_idx     = '0;
    for (int k = NCH; k >= 1; k--) begin
      w_idx = r_last_gnt + GW'(k);
      if (w_sel[w_idx]) begin
        w_gnt     = w_idx;
        w_gnt_vld = 1'b1;
      end
    end
  end

  assign w_beat_nxt = r_beat + RAM_AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ren      <= 1'b0;
      r_raddr    <= '0;
      r_rlength  <= '0;
      r_gnt      <= '0;
      r_last_gnt <= GW'(NCH - 1);
      r_beat     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ren <= 1'b0;
      if (io_bus.dvalid && (r_state != S_DATA)) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (io_bus.enable && w_gnt_vld) begin
            r_state    <= S_REQ;
            r_ren      <= 1'b1;
            r_gnt      <= w_gnt;
            r_last_gnt <= w_gnt;
            r_raddr    <= r_cur[w_gnt];
            r_rlength  <= w_len[w_gnt];
          end
        end
        S_REQ: begin
          r_state <= S_DATA;
          r_beat  <= '0;
        end
        S_DATA: begin
          if (io_bus.dvalid) begin
            r_beat <= w_beat_nxt;
            // dlast must coincide exactly with the final counted beat.
            if (io_bus.dlast != (w_beat_nxt == r_rlength)) r_err <= 1'b1;
            if (io_bus.dlast) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_done <= 1'b0;
      r_blk_ptr  <= '0;
    end else begin
      r_blk_done <= w_all_hold;
      if (w_all_hold) r_blk_ptr <= r_blk_ptr + BLKW'(1);
    end
  end

  assign w_dout           = io_bus.dout;
  assign io_bus.fifo_data = {NCH{w_dout}};
  assign io_bus.ren       = r_ren;
  assign io_bus.raddr     = r_raddr;
  assign io_bus.rlength   = r_rlength;
  assign io_bus.blk_done  = r_blk_done;
  assign io_bus.blk_ptr   = r_blk_ptr;
  assign io_bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_fifo_refill_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_refill_sched
// Brief    : Scoreboard bench: expected bursts queued with each descriptor,
//            checked against ren/raddr/rlength and routed beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_refill_sched;
  localparam int NCH = 4, RAM_AW = 8, DW = 24, FDW = 4, BURST_MAX = 8, BLKW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_refill_sched_if #(.NCH(NCH), .RAM_AW(RAM_AW), .DW(DW), .FDW(FDW), .BLKW(BLKW)) bus ();

  fifo_refill_sched #(
    .NCH(NCH), .RAM_AW(RAM_AW), .DW(DW), .FDW(FDW), .BURST_MAX(BURST_MAX), .BLKW(BLKW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic [RAM_AW-1:0] len;
    logic [1:0]        ch;
  } burst_t;

  burst_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_blk   = 0;
  int n_wr    = 0;

  always @(negedge clk) if (rst_n && bus.blk_done) n_blk++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic burst_t mk(input logic [7:0] a, input logic [7:0] l, input logic [1:0] c);
    burst_t b;
    b.addr = a;
    b.len  = l;
    b.ch   = c;
    return b;
  endfunction

  task automatic give_desc(input int ch, input logic [7:0] s, input logic [7:0] e, input logic last);
    @(negedge clk);
    check("desc_ready_before_load", bus.desc_ready[ch], 1'b1);
    bus.desc_valid[ch] = 1'b1;
    bus.desc_saddr[ch*RAM_AW +: RAM_AW] = s;
    bus.desc_eaddr[ch*RAM_AW +: RAM_AW] = e;
    bus.desc_last[ch] = last;
    @(negedge clk);
    bus.desc_valid[ch] = 1'b0;
  endtask

  task automatic set_count(input int ch, input logic [4:0] v);
    bus.fifo_count[ch*(FDW+1) +: FDW+1] = v;
  endtask

  // Waits for the next ren, checks it against the scoreboard and returns beats.
  // early > 0 ends the burst with dlast on that beat instead of beat len.
  task automatic serve(input int early);
    burst_t e;
    int t;
    int nb;
    logic [DW-1:0] d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.ren && t < 60);
    check("ren_seen", bus.ren, 1'b1);
    if (!bus.ren) begin
      if (exp_q.size() > 0) exp_q.delete(0);
      return;
    end
    e = exp_q.pop_front();
    check("raddr", bus.raddr, e.addr);
    check("rlength", bus.rlength, e.len);
    nb = (early > 0) ? early : int'(e.len);
    for (int b = 1; b <= nb; b++) begin
      @(negedge clk);
      if (b == 1) check("ren_one_cycle", bus.ren, 1'b0);
      d = DW'($urandom);
      bus.dvalid = 1'b1;
      bus.dlast  = (b == nb);
      bus.dout   = d;
      #1;
      check("fifo_wrreq", bus.fifo_wrreq, NCH'(1) << e.ch);
      check("fifo_data", bus.fifo_data[e.ch*DW +: DW], d);
      if (bus.fifo_wrreq[e.ch]) n_wr++;
    end
    @(negedge clk);
    bus.dvalid = 1'b0;
    bus.dlast  = 1'b0;
  endtask

  task automatic no_ren(input string tag, input int n);
    int cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.ren) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.desc_valid = '0;
    bus.desc_saddr = '0;
    bus.desc_eaddr = '0;
    bus.desc_last  = '0;
    bus.fifo_count = '0;
    bus.dvalid     = 1'b0;
    bus.dlast      = 1'b0;
    bus.dout       = '0;
    repeat (3) @(negedge clk);

    check("rst_ren", bus.ren, 1'b0);
    check("rst_raddr", bus.raddr, 8'h00);
    check("rst_rlength", bus.rlength, 8'h00);
    check("rst_wrreq", bus.fifo_wrreq, 4'h0);
    check("rst_desc_ready", bus.desc_ready, 4'hF);
    check("rst_blk_done", bus.blk_done, 1'b0);
    check("rst_blk_ptr", bus.blk_ptr, 4'h0);
    check("rst_err", bus.err, 1'b0);

    rst_n = 1'b1;
    bus.enable = 1'b1;

    // Remain-limited second burst, channel returns to EMPTY.
    exp_q.push_back(mk(8'h10, 8'd8, 2'd0));
    exp_q.push_back(mk(8'h18, 8'd4, 2'd0));
    n_wr = 0;
    give_desc(0, 8'h10, 8'h1C, 1'b0);
    serve(0);
    serve(0);
    check("ch0_wr_pulses", n_wr, 12);
    repeat (3) @(negedge clk);
    check("ch0_empty_again", bus.desc_ready[0], 1'b1);

    // Round-robin: move last_grant to 1, then load 1,3 (empty) and 2 (count 3).
    exp_q.push_back(mk(8'h20, 8'd2, 2'd1));
    give_desc(1, 8'h20, 8'h22, 1'b0);
    serve(0);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    set_count(2, 5'd3);
    give_desc(1, 8'h30, 8'h34, 1'b0);
    give_desc(3, 8'h40, 8'h44, 1'b0);
    give_desc(2, 8'h50, 8'h54, 1'b0);
    exp_q.push_back(mk(8'h40, 8'd4, 2'd3));
    exp_q.push_back(mk(8'h30, 8'd4, 2'd1));
    exp_q.push_back(mk(8'h50, 8'd4, 2'd2));
    no_ren("no_ren_while_disabled", 3);
    bus.enable = 1'b1;
    serve(0);
    serve(0);
    serve(0);
    repeat (3) @(negedge clk);
    set_count(2, 5'd0);

    // Nearly full FIFO belongs to no class, so it is never granted.
    set_count(0, 5'd14);
    give_desc(0, 8'h60, 8'h68, 1'b0);
    no_ren("no_ren_count14", 8);
    check("ch0_still_active", bus.desc_ready[0], 1'b0);
    set_count(0, 5'd0);
    exp_q.push_back(mk(8'h60, 8'd8, 2'd0));
    serve(0);
    repeat (3) @(negedge clk);

    // Address wrap-around and zero-length descriptor.
    exp_q.push_back(mk(8'hFC, 8'd8, 2'd0));
    give_desc(0, 8'hFC, 8'h04, 1'b0);
    serve(0);
    repeat (3) @(negedge clk);
    check("wrap_done", bus.desc_ready[0], 1'b1);
    give_desc(1, 8'h70, 8'h70, 1'b0);
    no_ren("no_ren_zero_len", 5);
    check("zero_len_done", bus.desc_ready[1], 1'b1);

    // Block barrier.
    n_blk = 0;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(mk(8'(8'h80 + 16*c), 8'd1, 2'(c)));
      give_desc(c, 8'(8'h80 + 16*c), 8'(8'h81 + 16*c), 1'b1);
      serve(0);
    end
    repeat (3) @(negedge clk);
    check("three_hold_ready", bus.desc_ready, 4'b1000);
    check("three_hold_no_blk", n_blk, 0);
    check("three_hold_ptr", bus.blk_ptr, 4'h0);
    bus.desc_saddr[0 +: RAM_AW] = 8'h90;
    bus.desc_eaddr[0 +: RAM_AW] = 8'h91;
    bus.desc_valid[0] = 1'b1;
    no_ren("hold_ignores_desc", 4);
    check("hold_not_ready", bus.desc_ready[0], 1'b0);
    bus.desc_valid[0] = 1'b0;
    exp_q.push_back(mk(8'hB0, 8'd1, 2'd3));
    give_desc(3, 8'hB0, 8'hB1, 1'b1);
    serve(0);
    repeat (6) @(negedge clk);
    check("blk_done_pulses", n_blk, 1);
    check("blk_ptr_adv", bus.blk_ptr, 4'h1);
    check("barrier_ready", bus.desc_ready, 4'hF);

    // Early dlast raises sticky err; FSM still returns to IDLE.
    check("err_clean", bus.err, 1'b0);
    exp_q.push_back(mk(8'hA0, 8'd4, 2'd0));
    give_desc(0, 8'hA0, 8'hA4, 1'b0);
    serve(3);
    check("err_early_dlast", bus.err, 1'b1);
    no_ren("no_ren_after_err", 4);
    check("err_sticky", bus.err, 1'b1);
    check("err_ch_done", bus.desc_ready[0], 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);

    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_err", bus.err, 1'b0);
    check("rst2_blk_ptr", bus.blk_ptr, 4'h0);
    check("rst2_ready", bus.desc_ready, 4'hF);
    rst_n = 1'b1;
    @(negedge clk);
    bus.dvalid = 1'b1;
    @(negedge clk);
    bus.dvalid = 1'b0;
    check("err_dvalid_idle", bus.err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
